// File: rtl/controlador_jogo.sv
// rtl/controlador_jogo.sv - naval-battle sequencer: game states, lives/hits, lookup request/ack
// CONTROLADOR_TIMEOUT_EN: abandon a lookup after TIMEOUT cycles without ack and raise erro.
module controlador_jogo #(
  parameter int VIDAS_INICIAIS = 3,
  parameter int NUM_ALVOS      = 5,
  parameter int TEMPO_FEEDBACK = 4
`ifdef CONTROLADOR_TIMEOUT_EN
  ,
  parameter int TIMEOUT        = 8
`endif
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic [1:0] modo,
  input  logic       confirmar,
  input  logic [2:0] coord_linha,
  input  logic [2:0] coord_coluna,
  input  logic       ack,
  input  logic [1:0] resultado,
  output logic       consulta,
  output logic [2:0] linha_lat,
  output logic [2:0] coluna_lat,
  output logic       en_preparacao,
  output logic       en_ataque,
  output logic       ligar_matriz,
  output logic       mapa_ok,
  output logic [1:0] vida,
  output logic [2:0] acertos,
  output logic [2:0] estado,
  output logic       erro,
  output logic       LED_R,
  output logic       LED_G,
  output logic       LED_B
);

  typedef enum logic [2:0] {
    DESLIGADO  = 3'b000,
    PREPARACAO = 3'b001,
    ESPERA     = 3'b010,
    CONSULTA   = 3'b011,
    RESULTADO  = 3'b100,
    VITORIA    = 3'b101,
    DERROTA    = 3'b110
  } estado_t;

  localparam logic [1:0] FB_R = 2'd0;
  localparam logic [1:0] FB_G = 2'd1;
  localparam logic [1:0] FB_B = 2'd2;

  localparam logic [1:0] VIDA_INI = 2'(VIDAS_INICIAIS);
  localparam logic [2:0] ALVOS    = 3'(NUM_ALVOS);
  localparam logic [7:0] FB_FIM   = 8'(TEMPO_FEEDBACK - 1);
`ifdef CONTROLADOR_TIMEOUT_EN
  localparam logic [7:0] TMO_FIM  = 8'(TIMEOUT - 1);
`endif

  estado_t    st, st_n;
  logic [1:0] vida_n, fb, fb_n;
  logic [2:0] acertos_n, linha_n, coluna_n;
  logic       mapa_ok_n, erro_n;
  logic [7:0] tmr, tmr_n;
  logic       consulta_n, en_prep_n, en_atq_n, ligar_n, led_r_n, led_g_n, led_b_n;

  assign estado = st;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      st            <= DESLIGADO;
      vida          <= '0;
      acertos       <= '0;
      mapa_ok       <= 1'b0;
      erro          <= 1'b0;
      linha_lat     <= '0;
      coluna_lat    <= '0;
      fb            <= FB_R;
      tmr           <= '0;
      consulta      <= 1'b0;
      en_preparacao <= 1'b0;
      en_ataque     <= 1'b0;
      ligar_matriz  <= 1'b0;
      LED_R         <= 1'b0;
      LED_G         <= 1'b0;
      LED_B         <= 1'b0;
    end else begin
      st            <= st_n;
      vida          <= vida_n;
      acertos       <= acertos_n;
      mapa_ok       <= mapa_ok_n;
      erro          <= erro_n;
      linha_lat     <= linha_n;
      coluna_lat    <= coluna_n;
      fb            <= fb_n;
      tmr           <= tmr_n;
      consulta      <= consulta_n;
      en_preparacao <= en_prep_n;
      en_ataque     <= en_atq_n;
      ligar_matriz  <= ligar_n;
      LED_R         <= led_r_n;
      LED_G         <= led_g_n;
      LED_B         <= led_b_n;
    end
  end

  always_comb begin
    st_n      = st;
    vida_n    = vida;
    acertos_n = acertos;
    mapa_ok_n = mapa_ok;
    erro_n    = erro;
    linha_n   = linha_lat;
    coluna_n  = coluna_lat;
    fb_n      = fb;
    tmr_n     = '0;

    if (modo == 2'b00) begin
      st_n      = DESLIGADO;
      vida_n    = '0;
      acertos_n = '0;
      mapa_ok_n = 1'b0;
    end else if (modo == 2'b01 && st != PREPARACAO) begin
      st_n      = PREPARACAO;
      vida_n    = VIDA_INI;
      acertos_n = '0;
      mapa_ok_n = 1'b0;
    end else begin
      case (st)
        DESLIGADO: ;
        PREPARACAO: begin
          if (confirmar) mapa_ok_n = 1'b1;
          if (modo[1] && mapa_ok) st_n = ESPERA;
        end
        ESPERA: begin
          if (confirmar) begin
            linha_n  = coord_linha;
            coluna_n = coord_coluna;
            erro_n   = 1'b0;
            // Off-board shots skip the lookup and are reported as blue feedback
            if (coord_linha > 3'd6 || coord_coluna > 3'd4) begin
              st_n = RESULTADO;
              fb_n = FB_B;
            end else begin
              st_n = CONSULTA;
            end
          end
        end
        CONSULTA: begin
          if (ack) begin
            st_n = RESULTADO;
            case (resultado)
              2'b00: begin
                if (vida != 2'd0) vida_n = vida - 2'd1;
                fb_n = FB_R;
              end
              2'b01: begin
                if (acertos != 3'd7) acertos_n = acertos + 3'd1;
                fb_n = FB_G;
              end
              default: fb_n = FB_B;
            endcase
          end
`ifdef CONTROLADOR_TIMEOUT_EN
          else if (tmr == TMO_FIM) begin
            st_n   = ESPERA;
            erro_n = 1'b1;
          end else begin
            tmr_n = tmr + 8'd1;
          end
`endif
        end
        RESULTADO: begin
          if (tmr == FB_FIM) begin
            if (vida == 2'd0)          st_n = DERROTA;
            else if (acertos == ALVOS) st_n = VITORIA;
            else                       st_n = ESPERA;
          end else begin
            tmr_n = tmr + 8'd1;
          end
        end
        VITORIA, DERROTA: ;
        default: st_n = DESLIGADO;
      endcase
    end

`ifndef CONTROLADOR_TIMEOUT_EN
    erro_n = 1'b0;
`endif

    // Decode from the next state so every status output is a plain flop
    consulta_n = (st_n == CONSULTA);
    en_prep_n  = (st_n == PREPARACAO);
    en_atq_n   = (st_n == ESPERA);
    ligar_n    = st_n inside {PREPARACAO, ESPERA, CONSULTA, RESULTADO};
    led_r_n    = (st_n == RESULTADO && fb_n == FB_R) || (st_n == DERROTA);
    led_g_n    = (st_n == RESULTADO && fb_n == FB_G) || (st_n == VITORIA);
    led_b_n    = (st_n == RESULTADO && fb_n == FB_B) || (st_n == PREPARACAO && !mapa_ok_n);
  end

endmodule

// File: tb/tb_controlador_jogo.sv
// tb/tb_controlador_jogo.sv - randomized + directed bench for controlador_jogo against a game model
// Honours CONTROLADOR_TIMEOUT_EN the same way as the design.
module tb_controlador_jogo;

  localparam int VI = 3;
  localparam int NA = 5;
  localparam int TF = 4;
  localparam int TO = 8;
`ifdef CONTROLADOR_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int S_OFF = 0, S_PREP = 1, S_WAIT = 2, S_ASK = 3, S_RES = 4, S_WIN = 5, S_LOSE = 6;
  localparam int C_R = 0, C_G = 1, C_B = 2;

  logic       clock_in, reset_n;
  logic [1:0] modo, resultado;
  logic       confirmar, ack;
  logic [2:0] coord_linha, coord_coluna;
  logic       consulta, en_preparacao, en_ataque, ligar_matriz, mapa_ok, erro;
  logic       LED_R, LED_G, LED_B;
  logic [2:0] linha_lat, coluna_lat, acertos, estado;
  logic [1:0] vida;

  controlador_jogo #(.VIDAS_INICIAIS(VI), .NUM_ALVOS(NA), .TEMPO_FEEDBACK(TF)) dut (
    .clock_in(clock_in), .reset_n(reset_n), .modo(modo), .confirmar(confirmar),
    .coord_linha(coord_linha), .coord_coluna(coord_coluna), .ack(ack), .resultado(resultado),
    .consulta(consulta), .linha_lat(linha_lat), .coluna_lat(coluna_lat),
    .en_preparacao(en_preparacao), .en_ataque(en_ataque), .ligar_matriz(ligar_matriz),
    .mapa_ok(mapa_ok), .vida(vida), .acertos(acertos), .estado(estado), .erro(erro),
    .LED_R(LED_R), .LED_G(LED_G), .LED_B(LED_B)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  // Game model: phase, lives, hits, feedback colour with a countdown of visible cycles
  int         m_st, m_vida, m_hits, m_fb, m_left, m_budget;
  logic       m_mapa, m_erro;
  logic [2:0] m_lin, m_col;

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
    end
  endtask

  task automatic model_reset();
    m_st = S_OFF; m_vida = 0; m_hits = 0; m_fb = C_R; m_left = 0; m_budget = 0;
    m_mapa = 1'b0; m_erro = 1'b0; m_lin = 3'd0; m_col = 3'd0;
  endtask

  task automatic model_step();
    logic go;
    if (modo == 2'b00) begin
      m_st = S_OFF; m_vida = 0; m_hits = 0; m_mapa = 1'b0;
    end else if (modo == 2'b01 && m_st != S_PREP) begin
      m_st = S_PREP; m_vida = VI; m_hits = 0; m_mapa = 1'b0;
    end else begin
      case (m_st)
        S_PREP: begin
          go = modo[1] && m_mapa;
          if (confirmar) m_mapa = 1'b1;
          if (go) m_st = S_WAIT;
        end
        S_WAIT: if (confirmar) begin
          m_lin = coord_linha; m_col = coord_coluna; m_erro = 1'b0;
          if (coord_linha <= 6 && coord_coluna <= 4) begin
            m_st = S_ASK; m_budget = TO;
          end else begin
            m_st = S_RES; m_fb = C_B; m_left = TF;
          end
        end
        S_ASK: begin
          if (ack) begin
            if (resultado == 2'b00) begin
              m_vida = (m_vida > 0) ? m_vida - 1 : 0; m_fb = C_R;
            end else if (resultado == 2'b01) begin
              m_hits = (m_hits < 7) ? m_hits + 1 : 7; m_fb = C_G;
            end else begin
              m_fb = C_B;
            end
            m_st = S_RES; m_left = TF;
          end else if (TMO_EN) begin
            m_budget--;
            if (m_budget == 0) begin m_st = S_WAIT; m_erro = 1'b1; end
          end
        end
        S_RES: begin
          m_left--;
          if (m_left == 0) m_st = (m_vida == 0) ? S_LOSE : ((m_hits == NA) ? S_WIN : S_WAIT);
        end
        default: ;
      endcase
    end
  endtask

  always @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  always @(negedge clock_in) begin
    if (run_cmp) begin
      chk("estado", 8'(estado), 8'(m_st));
      chk("consulta", 8'(consulta), 8'(m_st == S_ASK));
      chk("en_preparacao", 8'(en_preparacao), 8'(m_st == S_PREP));
      chk("en_ataque", 8'(en_ataque), 8'(m_st == S_WAIT));
      chk("ligar_matriz", 8'(ligar_matriz), 8'(m_st >= S_PREP && m_st <= S_RES));
      chk("mapa_ok", 8'(mapa_ok), 8'(m_mapa));
      chk("vida", 8'(vida), 8'(m_vida));
      chk("acertos", 8'(acertos), 8'(m_hits));
      chk("linha_lat", 8'(linha_lat), 8'(m_lin));
      chk("coluna_lat", 8'(coluna_lat), 8'(m_col));
      chk("erro", 8'(erro), 8'(m_erro));
      chk("LED_R", 8'(LED_R), 8'((m_st == S_RES && m_fb == C_R) || m_st == S_LOSE));
      chk("LED_G", 8'(LED_G), 8'((m_st == S_RES && m_fb == C_G) || m_st == S_WIN));
      chk("LED_B", 8'(LED_B), 8'((m_st == S_RES && m_fb == C_B) || (m_st == S_PREP && !m_mapa)));
    end
  end

  task automatic ciclo(input logic [1:0] m, input logic c, input logic [2:0] l, input logic [2:0] cc,
                       input logic a, input logic [1:0] r);
    modo = m; confirmar = c; coord_linha = l; coord_coluna = cc; ack = a; resultado = r;
    @(posedge clock_in);
    @(negedge clock_in);
  endtask

  task automatic idle(input logic [1:0] m);
    ciclo(m, 1'b0, 3'd0, 3'd0, 1'b0, 2'b00);
  endtask

  task automatic to_attack();
    ciclo(2'b01, 1'b0, 3'd0, 3'd0, 1'b0, 2'b00);
    ciclo(2'b01, 1'b1, 3'd0, 3'd0, 1'b0, 2'b00);
    idle(2'b10);
  endtask

  task automatic tiro(input logic [2:0] l, input logic [2:0] c, input logic [1:0] r,
                      output int nr, output int ng, output int nb);
    ciclo(2'b10, 1'b1, l, c, 1'b0, 2'b00);
    ciclo(2'b10, 1'b0, 3'd0, 3'd0, 1'b1, r);
    nr = int'(LED_R); ng = int'(LED_G); nb = int'(LED_B);
    repeat (5) begin
      idle(2'b10);
      nr += int'(LED_R); ng += int'(LED_G); nb += int'(LED_B);
    end
  endtask

  int nr, ng, nb, nc;

  initial begin
    reset_n = 1'b0; modo = 2'b00; confirmar = 1'b0; ack = 1'b0; resultado = 2'b00;
    coord_linha = 3'd0; coord_coluna = 3'd0;
    model_reset();
    repeat (2) @(negedge clock_in);
    reset_n = 1'b1;
    run_cmp = 1'b1;
    idle(2'b00);
    chk("reset_estado", 8'(estado), 8'd0);

    // Three water results drain the lives and end in defeat
    to_attack();
    chk("attack_estado", 8'(estado), 8'd2);
    tiro(3'd1, 3'd1, 2'b00, nr, ng, nb);
    chk("water1_ledr_cycles", 8'(nr), 8'd4);
    chk("water1_vida", 8'(vida), 8'd2);
    tiro(3'd2, 3'd0, 2'b00, nr, ng, nb);
    chk("water2_ledr_cycles", 8'(nr), 8'd4);
    chk("water2_vida", 8'(vida), 8'd1);
    tiro(3'd6, 3'd4, 2'b00, nr, ng, nb);
    chk("loss_estado", 8'(estado), 8'd6);
    chk("loss_vida", 8'(vida), 8'd0);
    chk("loss_matriz", 8'(ligar_matriz), 8'd0);

    // Five hits win; mode off clears everything
    idle(2'b00);
    to_attack();
    for (int i = 0; i < 5; i++) begin
      tiro(3'(i), 3'd3, 2'b01, nr, ng, nb);
      if (i < 4) chk("hit_ledg_cycles", 8'(ng), 8'd4);
    end
    chk("win_estado", 8'(estado), 8'd5);
    chk("win_acertos", 8'(acertos), 8'd5);
    chk("win_ledg", 8'(LED_G), 8'd1);
    idle(2'b00);
    chk("off_estado", 8'(estado), 8'd0);
    chk("off_acertos", 8'(acertos), 8'd0);

    // Off-board shot: blue feedback, no lookup
    to_attack();
    nc = 0; nb = 0;
    ciclo(2'b10, 1'b1, 3'd7, 3'd2, 1'b0, 2'b00);
    nc += int'(consulta); nb += int'(LED_B);
    repeat (5) begin idle(2'b10); nc += int'(consulta); nb += int'(LED_B); end
    chk("invalid_consulta", 8'(nc), 8'd0);
    chk("invalid_ledb_cycles", 8'(nb), 8'd4);
    chk("invalid_vida", 8'(vida), 8'd3);
    chk("invalid_linha_lat", 8'(linha_lat), 8'd7);

    // Attack request without a confirmed map
    idle(2'b00);
    idle(2'b01);
    repeat (3) idle(2'b10);
    chk("nomap_estado", 8'(estado), 8'd1);
    chk("nomap_ledb", 8'(LED_B), 8'd1);

    // ack and mode-off on the same edge: mode-off wins
    ciclo(2'b10, 1'b1, 3'd0, 3'd0, 1'b0, 2'b00);
    idle(2'b10);
    ciclo(2'b10, 1'b1, 3'd1, 3'd1, 1'b0, 2'b00);
    ciclo(2'b00, 1'b0, 3'd0, 3'd0, 1'b1, 2'b01);
    chk("ackoff_estado", 8'(estado), 8'd0);
    chk("ackoff_acertos", 8'(acertos), 8'd0);

    // Lookup without ack
    to_attack();
    ciclo(2'b10, 1'b1, 3'd2, 3'd2, 1'b0, 2'b00);
`ifdef CONTROLADOR_TIMEOUT_EN
    repeat (TO - 1) idle(2'b10);
    chk("tmo_consulta_held", 8'(consulta), 8'd1);
    idle(2'b10);
    chk("tmo_consulta", 8'(consulta), 8'd0);
    chk("tmo_erro", 8'(erro), 8'd1);
    chk("tmo_estado", 8'(estado), 8'd2);
    ciclo(2'b10, 1'b1, 3'd3, 3'd3, 1'b0, 2'b00);
    chk("tmo_erro_clear", 8'(erro), 8'd0);
`else
    repeat (100) idle(2'b10);
    chk("noto_consulta", 8'(consulta), 8'd1);
    chk("noto_erro", 8'(erro), 8'd0);
`endif
    ciclo(2'b10, 1'b0, 3'd0, 3'd0, 1'b1, 2'b10);
    repeat (5) idle(2'b10);

    // Asynchronous reset in the middle of a lookup
    ciclo(2'b10, 1'b1, 3'd4, 3'd1, 1'b0, 2'b00);
    chk("pre_reset_consulta", 8'(consulta), 8'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_estado", 8'(estado), 8'd0);
    chk("areset_consulta", 8'(consulta), 8'd0);
    chk("areset_vida", 8'(vida), 8'd0);
    chk("areset_leds", 8'({LED_R, LED_G, LED_B}), 8'd0);
    @(negedge clock_in);
    reset_n = 1'b1;

    // Random play checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [1:0] m;
      r = int'($urandom_range(0, 99));
      m = (r < 2) ? 2'b00 : ((r < 6) ? 2'b01 : 2'(2 + $urandom_range(0, 1)));
      ciclo(m, ($urandom_range(0, 99) < 25), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 99) < 35), 2'($urandom_range(0, 3)));
    end

    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
